// File: rtl/lane_unit.sv
// lane_unit: one lane combatant; deploys, walks, attacks, dies and respawns.
// Optional health regeneration is enabled by defining UNIT_REGEN_EN.
module lane_unit #(
  parameter int NUM_TYPES     = 4,
  parameter int POS_W         = 9,
  parameter int HP_W          = 8,
  parameter int DMG_W         = 8,
  parameter int BASE_POWER    = 16,
  parameter int MAX_HP        = 255,
  parameter int SPAWN_POS     = 511,
  parameter int END_POS       = 0,
  parameter bit DIR           = 1'b0,
  parameter int ATTACK_PERIOD = 1,
  parameter int DEAD_TICKS    = 10,
  parameter int REGEN_PERIOD  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 gameTick,
  input  logic                 purchase,
  input  logic [NUM_TYPES-1:0] typeSel,
  input  logic                 moveSCEN,
  input  logic                 damageSCEN,
  input  logic [DMG_W-1:0]     damageIn,
  output logic [POS_W-1:0]     position,
  output logic [DMG_W-1:0]     damageOut,
  output logic [HP_W-1:0]      health,
  output logic                 alive,
  output logic                 dead,
  output logic                 breach
);
  localparam int CW = ATTACK_PERIOD > 1 ? $clog2(ATTACK_PERIOD) : 1;
  localparam int DW = DEAD_TICKS > 1 ? $clog2(DEAD_TICKS) : 1;
  localparam int MW = DMG_W > HP_W ? DMG_W : HP_W;
  typedef enum logic [1:0] {IDLE, DEPLOY, ALIVE, DEAD} state_t;
  state_t               state_q, state_d;
  logic [NUM_TYPES-1:0] type_q, type_d;
  logic [POS_W-1:0]     pos_q, pos_d, pos_mv;
  logic [HP_W-1:0]      hp_q, hp_d, hp_dm, hp_rg;
  logic [DMG_W-1:0]     dmg_q, dmg_d, pow_q, pow_d, pow_sel;
  logic                 brk_q, brk_d, kill;
  logic [CW-1:0]        cd_q, cd_d;
  logic [DW-1:0]        dc_q, dc_d;
  assign kill   = damageSCEN && (MW'(damageIn) >= MW'(hp_q));
  assign hp_dm  = damageSCEN ? hp_q - HP_W'(damageIn) : hp_q;
  assign pos_mv = pos_q == POS_W'(END_POS) ? pos_q : DIR ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
  always_comb begin
    pow_sel = '0;
    for (int k = 0; k < NUM_TYPES; k++)
      if (type_q[k]) pow_sel = pow_sel | DMG_W'(BASE_POWER << k);
  end
`ifdef UNIT_REGEN_EN
  localparam int RW = REGEN_PERIOD > 1 ? $clog2(REGEN_PERIOD) : 1;
  logic [RW-1:0] rg_q, rg_d;
  logic          rg_hit;
  assign rg_hit = rg_q == RW'(REGEN_PERIOD - 1);
  assign hp_rg  = !rg_hit ? hp_dm : hp_dm >= HP_W'(MAX_HP) ? hp_dm : hp_dm + HP_W'(1);
  always_comb begin
    rg_d = rg_q;
    if (state_q == DEPLOY) rg_d = '0;
    else if (state_q == ALIVE && gameTick && !kill) rg_d = rg_hit ? '0 : rg_q + RW'(1);
  end
  always_ff @(posedge clk) rg_q <= reset ? '0 : rg_d;
`else
  assign hp_rg = hp_dm;
`endif
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    pos_d   = pos_q;
    hp_d    = hp_q;
    dmg_d   = '0;
    brk_d   = 1'b0;
    pow_d   = pow_q;
    cd_d    = cd_q;
    dc_d    = dc_q;
    case (state_q)
      IDLE: if (purchase && $onehot(typeSel)) begin
        type_d  = typeSel;
        state_d = DEPLOY;
      end
      DEPLOY: begin
        hp_d    = HP_W'(MAX_HP);
        pow_d   = pow_sel;
        pos_d   = POS_W'(SPAWN_POS);
        cd_d    = '0;
        dc_d    = '0;
        state_d = ALIVE;
      end
      ALIVE: if (gameTick) begin
        if (kill) begin
          hp_d    = '0;
          state_d = DEAD;
        end else begin
          hp_d = hp_rg;
          if (moveSCEN) begin
            pos_d = pos_mv;
            if (pos_mv == POS_W'(END_POS)) begin
              brk_d   = 1'b1;
              state_d = DEAD;
            end
          end else if (cd_q == '0) begin
            dmg_d = pow_q;
            cd_d  = CW'(ATTACK_PERIOD - 1);
          end else cd_d = cd_q - CW'(1);
        end
      end
      DEAD: if (gameTick) begin
        if (dc_q == DW'(DEAD_TICKS - 1)) begin
          state_d = IDLE;
          pos_d   = POS_W'(SPAWN_POS);
          hp_d    = '0;
          dc_d    = '0;
        end else dc_d = dc_q + DW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      type_q  <= '0;
      pos_q   <= POS_W'(SPAWN_POS);
      hp_q    <= '0;
      dmg_q   <= '0;
      brk_q   <= 1'b0;
      pow_q   <= '0;
      cd_q    <= '0;
      dc_q    <= '0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      pos_q   <= pos_d;
      hp_q    <= hp_d;
      dmg_q   <= dmg_d;
      brk_q   <= brk_d;
      pow_q   <= pow_d;
      cd_q    <= cd_d;
      dc_q    <= dc_d;
    end
  end
  assign position  = pos_q;
  assign damageOut = dmg_q;
  assign health    = hp_q;
  assign breach    = brk_q;
  assign alive     = state_q == ALIVE;
  assign dead      = state_q == DEAD;
endmodule

// File: tb/tb_lane_unit.sv
// tb_lane_unit: directed checks of lane_unit; u_a uses defaults, u_b a short lane with slow attacks.
module tb_lane_unit;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       gameTick = 1'b0;
  logic       purchase_a = 1'b0;
  logic       purchase_b = 1'b0;
  logic [3:0] typeSel = '0;
  logic       moveSCEN = 1'b0;
  logic       damageSCEN = 1'b0;
  logic [7:0] damageIn = '0;
  logic [8:0] pos_a, pos_b;
  logic [7:0] dmg_a, dmg_b, hp_a, hp_b;
  logic       alive_a, alive_b, dead_a, dead_b, brk_a, brk_b;
  int         checks = 0;
  int         errors = 0;
  int         exp_dmg [6] = '{16, 0, 0, 16, 0, 0};
  always #5 clk = ~clk;
  lane_unit u_a (
    .clk(clk), .reset(reset), .gameTick(gameTick), .purchase(purchase_a), .typeSel(typeSel),
    .moveSCEN(moveSCEN), .damageSCEN(damageSCEN), .damageIn(damageIn), .position(pos_a),
    .damageOut(dmg_a), .health(hp_a), .alive(alive_a), .dead(dead_a), .breach(brk_a)
  );
  lane_unit #(.SPAWN_POS(2), .ATTACK_PERIOD(3)) u_b (
    .clk(clk), .reset(reset), .gameTick(gameTick), .purchase(purchase_b), .typeSel(typeSel),
    .moveSCEN(moveSCEN), .damageSCEN(damageSCEN), .damageIn(damageIn), .position(pos_b),
    .damageOut(dmg_b), .health(hp_b), .alive(alive_b), .dead(dead_b), .breach(brk_b)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic tick();
    gameTick = 1'b1;
    step();
    gameTick = 1'b0;
  endtask
  initial begin
    step();
    step();
    reset = 1'b0;
    check("rst_pos", pos_a, 511);
    check("rst_hp", hp_a, 0);
    check("rst_alive", alive_a, 0);
    check("rst_dead", dead_a, 0);
    check("rst_dmg", dmg_a, 0);
    check("rst_brk", brk_a, 0);
    typeSel = 4'b0110;
    purchase_a = 1'b1;
    step();
    purchase_a = 1'b0;
    step();
    step();
    check("multihot_ignored", alive_a, 0);
    typeSel = 4'b0100;
    purchase_a = 1'b1;
    step();
    purchase_a = 1'b0;
    check("deploy_not_alive", alive_a, 0);
    step();
    check("alive", alive_a, 1);
    check("deploy_hp", hp_a, 255);
    check("deploy_pos", pos_a, 511);
    typeSel = 4'b0001;
    purchase_a = 1'b1;
    step();
    purchase_a = 1'b0;
    check("rebuy_alive", alive_a, 1);
    check("rebuy_hp", hp_a, 255);
    tick();
    check("attack_t2", dmg_a, 64);
    step();
    check("attack_pulse_end", dmg_a, 0);
    moveSCEN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("move_no_dmg", dmg_a, 0);
      check("move_pos", pos_a, 510 - i);
    end
    step();
    check("no_tick_hold", pos_a, 508);
    damageSCEN = 1'b1;
    damageIn = 8'd100;
    tick();
    check("hp_155", hp_a, 155);
    check("pos_507", pos_a, 507);
    tick();
    check("hp_55", hp_a, 55);
    damageIn = 8'd55;
    tick();
    damageSCEN = 1'b0;
    moveSCEN = 1'b0;
    check("kill_dead", dead_a, 1);
    check("kill_alive", alive_a, 0);
    check("kill_hp", hp_a, 0);
    check("kill_pos", pos_a, 506);
    check("kill_no_brk", brk_a, 0);
    step();
    step();
    step();
    for (int i = 0; i < 9; i++) tick();
    check("dead_9_ticks", dead_a, 1);
    check("dead_dmg", dmg_a, 0);
    tick();
    check("respawn_dead", dead_a, 0);
    check("respawn_alive", alive_a, 0);
    check("respawn_pos", pos_a, 511);
    typeSel = 4'b0001;
    purchase_b = 1'b1;
    step();
    purchase_b = 1'b0;
    step();
    check("b_alive", alive_b, 1);
    check("b_pos", pos_b, 2);
    check("a_stays_idle", alive_a, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("cooldown_%0d", i + 1), dmg_b, exp_dmg[i]);
    end
    moveSCEN = 1'b1;
    tick();
    check("b_pos_1", pos_b, 1);
    check("b_no_brk", brk_b, 0);
    tick();
    moveSCEN = 1'b0;
    check("b_pos_0", pos_b, 0);
    check("b_brk", brk_b, 1);
    check("b_brk_dead", dead_b, 1);
    step();
    check("b_brk_pulse_end", brk_b, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("b_rst_dead", dead_b, 0);
    check("b_rst_alive", alive_b, 0);
    check("b_rst_pos", pos_b, 2);
    check("b_rst_hp", hp_b, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
